// File: rtl/itcm_fetch_arbiter_pkg.sv
// Shared types for the ITCM fetch/data arbiter: response-source and FSM encodings
// plus default bus widths.
package itcm_fetch_arbiter_pkg;

  localparam int unsigned AddrWidthDefault = 32;
  localparam int unsigned DataWidthDefault = 32;
  localparam logic [3:0]  BeAll            = 4'hF;

  typedef enum logic [1:0] {
    RespNone  = 2'd0,
    RespItcmI = 2'd1,
    RespItcmD = 2'd2,
    RespAhb   = 2'd3
  } resp_src_e;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StAhbWait = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/itcm_starve_ctr.sv
// Saturating starvation counter: counts lost arbitration rounds up to Limit and
// flags when the starved requester must be forced to win.
module itcm_starve_ctr #(
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign at_limit_o = (cnt_q == CntW'(Limit));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/itcm_fetch_arbiter.sv
// Shares the single-port ITCM between instruction fetch and the data path, and sends
// out-of-window fetches to a one-outstanding AHB fetch master.
module itcm_fetch_arbiter
  import itcm_fetch_arbiter_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = AddrWidthDefault,
  parameter int unsigned           DATA_WIDTH   = DataWidthDefault,
  parameter logic [ADDR_WIDTH-1:0] ITCM_BASE    = 32'h0000_0000,
  parameter int unsigned           ITCM_SIZE    = 32'h0001_0000,
  parameter int unsigned           STARVE_LIMIT = 4
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  // fetch stage
  input  logic [ADDR_WIDTH-1:0] next_pc,
  output logic                  instr_read_data_valid,
  output logic [DATA_WIDTH-1:0] instr_read_data,
  output logic                  addr_AHB,
  // data side
  input  logic                  dmem_req,
  input  logic                  dmem_we,
  input  logic [3:0]            dmem_be,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_rvalid,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  // ITCM SRAM
  output logic                  itcm_cs,
  output logic                  itcm_we,
  output logic [3:0]            itcm_be,
  output logic [ADDR_WIDTH-3:0] itcm_addr,
  output logic [DATA_WIDTH-1:0] itcm_wdata,
  input  logic [DATA_WIDTH-1:0] itcm_rdata,
  // AHB fetch master
  output logic                  ahb_if_req,
  output logic [ADDR_WIDTH-1:0] ahb_if_addr,
  input  logic                  ahb_if_ready,
  input  logic [DATA_WIDTH-1:0] ahb_if_rdata
);

  localparam int unsigned SizeLog2 = $clog2(ITCM_SIZE);

  fsm_state_e            state_d, state_q;
  resp_src_e             resp_src_d, resp_src_q;
  logic [ADDR_WIDTH-1:0] ahb_addr_d, ahb_addr_q;
  logic [DATA_WIDTH-1:0] ahb_rdata_d, ahb_rdata_q;
  logic                  dmem_rd_ahb_d, dmem_rd_ahb_q;

  logic                  fetch_in_itcm;
  logic                  fetch_gnt, data_gnt;
  logic                  starve_inc, starve_clr, starve_at_limit;
  logic [ADDR_WIDTH-3:0] fetch_word, data_word;
  logic                  unused_addr_lsb;

  assign fetch_in_itcm = (next_pc[ADDR_WIDTH-1:SizeLog2] == ITCM_BASE[ADDR_WIDTH-1:SizeLog2]);
  assign fetch_word    = next_pc[ADDR_WIDTH-1:2] - ITCM_BASE[ADDR_WIDTH-1:2];
  assign data_word     = dmem_addr[ADDR_WIDTH-1:2] - ITCM_BASE[ADDR_WIDTH-1:2];
  assign unused_addr_lsb = ^{dmem_addr[1:0], ITCM_BASE[1:0]};

  itcm_starve_ctr #(
    .Limit (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk_i      (cpu_clk),
    .rst_ni     (cpu_rstn),
    .clr_i      (starve_clr),
    .inc_i      (starve_inc),
    .at_limit_o (starve_at_limit)
  );

  // Arbitration, FSM next state and response-source selection.
  always_comb begin
    state_d       = state_q;
    ahb_addr_d    = ahb_addr_q;
    ahb_rdata_d   = ahb_rdata_q;
    resp_src_d    = RespNone;
    dmem_rd_ahb_d = 1'b0;
    fetch_gnt     = 1'b0;
    data_gnt      = 1'b0;
    starve_inc    = 1'b0;
    starve_clr    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (fetch_in_itcm) begin
          if (!dmem_req || starve_at_limit) begin
            fetch_gnt  = 1'b1;
            starve_clr = 1'b1;
          end else begin
            data_gnt   = 1'b1;
            starve_inc = 1'b1;
          end
        end else begin
          // Fetch needs no SRAM this cycle, so data may use it.
          data_gnt   = dmem_req;
          ahb_addr_d = next_pc;
          state_d    = StAhbWait;
          starve_clr = 1'b1;
        end
      end
      StAhbWait: begin
        data_gnt = dmem_req;
        if (ahb_if_ready) begin
          ahb_rdata_d = ahb_if_rdata;
          state_d     = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    if ((state_q == StAhbWait) && ahb_if_ready) begin
      resp_src_d    = RespAhb;
      // A data read granted alongside the AHB completion still owes an rvalid.
      dmem_rd_ahb_d = data_gnt && !dmem_we;
    end else if (fetch_gnt) begin
      resp_src_d = RespItcmI;
    end else if (data_gnt && !dmem_we) begin
      resp_src_d = RespItcmD;
    end
  end

  // SRAM port mux; fetch and data grants are mutually exclusive.
  always_comb begin
    itcm_cs    = fetch_gnt | data_gnt;
    itcm_we    = data_gnt & dmem_we;
    itcm_be    = 4'b0000;
    itcm_addr  = '0;
    itcm_wdata = '0;
    if (data_gnt) begin
      itcm_be   = dmem_be;
      itcm_addr = data_word;
      if (dmem_we) begin
        itcm_wdata = dmem_wdata;
      end
    end else if (fetch_gnt) begin
      itcm_be   = BeAll;
      itcm_addr = fetch_word;
    end
  end

  always_comb begin
    dmem_gnt              = data_gnt;
    dmem_rvalid           = (resp_src_q == RespItcmD) || dmem_rd_ahb_q;
    dmem_rdata            = dmem_rvalid ? itcm_rdata : '0;
    instr_read_data_valid = (resp_src_q == RespItcmI) || (resp_src_q == RespAhb);
    instr_read_data       = '0;
    if (resp_src_q == RespItcmI) begin
      instr_read_data = itcm_rdata;
    end else if (resp_src_q == RespAhb) begin
      instr_read_data = ahb_rdata_q;
    end
    addr_AHB    = (state_q == StAhbWait) || (resp_src_q == RespAhb);
    ahb_if_req  = (state_q == StAhbWait);
    ahb_if_addr = ahb_if_req ? ahb_addr_q : '0;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q       <= StRun;
      resp_src_q    <= RespNone;
      ahb_addr_q    <= '0;
      ahb_rdata_q   <= '0;
      dmem_rd_ahb_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_src_q    <= resp_src_d;
      ahb_addr_q    <= ahb_addr_d;
      ahb_rdata_q   <= ahb_rdata_d;
      dmem_rd_ahb_q <= dmem_rd_ahb_d;
    end
  end

endmodule

// File: tb/tb_itcm_fetch_arbiter.sv
// Directed bench for itcm_fetch_arbiter with a 1-cycle-latency SRAM model whose
// word i initially holds 0xA500_0000 | i.
module tb_itcm_fetch_arbiter;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic [31:0] next_pc = '0;
  logic        instr_read_data_valid;
  logic [31:0] instr_read_data;
  logic        addr_AHB;
  logic        dmem_req = 1'b0;
  logic        dmem_we = 1'b0;
  logic [3:0]  dmem_be = '0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        itcm_cs;
  logic        itcm_we;
  logic [3:0]  itcm_be;
  logic [29:0] itcm_addr;
  logic [31:0] itcm_wdata;
  logic [31:0] itcm_rdata = '0;
  logic        ahb_if_req;
  logic [31:0] ahb_if_addr;
  logic        ahb_if_ready = 1'b0;
  logic [31:0] ahb_if_rdata = '0;

  int total = 0;
  int bad = 0;
  bit mem_init = 1'b0;
  logic [31:0] mem [0:1023];

  always #5 cpu_clk = ~cpu_clk;

  itcm_fetch_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .cpu_clk               (cpu_clk),
    .cpu_rstn              (cpu_rstn),
    .next_pc               (next_pc),
    .instr_read_data_valid (instr_read_data_valid),
    .instr_read_data       (instr_read_data),
    .addr_AHB              (addr_AHB),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_be               (dmem_be),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_gnt              (dmem_gnt),
    .dmem_rvalid           (dmem_rvalid),
    .dmem_rdata            (dmem_rdata),
    .itcm_cs               (itcm_cs),
    .itcm_we               (itcm_we),
    .itcm_be               (itcm_be),
    .itcm_addr             (itcm_addr),
    .itcm_wdata            (itcm_wdata),
    .itcm_rdata            (itcm_rdata),
    .ahb_if_req            (ahb_if_req),
    .ahb_if_addr           (ahb_if_addr),
    .ahb_if_ready          (ahb_if_ready),
    .ahb_if_rdata          (ahb_if_rdata)
  );

  // SRAM model; contents are loaded on the first clock edge.
  always @(posedge cpu_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem_init <= 1'b1;
    end else if (itcm_cs) begin
      if (itcm_we) begin
        for (int b = 0; b < 4; b++) begin
          if (itcm_be[b]) mem[itcm_addr[9:0]][8*b +: 8] <= itcm_wdata[8*b +: 8];
        end
      end else begin
        itcm_rdata <= mem[itcm_addr[9:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    logic exp_gnt;
    logic prev_fetch;

    // Reset
    repeat (3) tick();
    check("rst_valid", 64'(instr_read_data_valid), 64'h0);
    check("rst_instr", 64'(instr_read_data), 64'h0);
    check("rst_ahb_req", 64'(ahb_if_req), 64'h0);
    check("rst_addr_ahb", 64'(addr_AHB), 64'h0);
    check("rst_rvalid", 64'(dmem_rvalid), 64'h0);
    cpu_rstn = 1'b1;

    // Back-to-back ITCM fetches
    next_pc = 32'h0;
    #1;
    check("f0_cs", 64'(itcm_cs), 64'h1);
    check("f0_addr", 64'(itcm_addr), 64'h0);
    check("f0_gnt", 64'(dmem_gnt), 64'h0);
    tick();
    next_pc = 32'h4;
    #1;
    check("f0_valid", 64'(instr_read_data_valid), 64'h1);
    check("f0_instr", 64'(instr_read_data), 64'hA500_0000);
    tick();
    next_pc = 32'h8;
    #1;
    check("f1_instr", 64'(instr_read_data), 64'hA500_0001);
    tick();

    // Data read collides with fetch of 0x10
    next_pc   = 32'h10;
    dmem_req  = 1'b1;
    dmem_we   = 1'b0;
    dmem_addr = 32'h100;
    #1;
    check("f2_instr", 64'(instr_read_data), 64'hA500_0002);
    check("col_gnt", 64'(dmem_gnt), 64'h1);
    check("col_itcm_addr", 64'(itcm_addr), 64'h40);
    tick();
    dmem_req = 1'b0;
    #1;
    check("col_rvalid", 64'(dmem_rvalid), 64'h1);
    check("col_rdata", 64'(dmem_rdata), 64'hA500_0040);
    check("col_ivalid", 64'(instr_read_data_valid), 64'h0);
    check("col_refetch_addr", 64'(itcm_addr), 64'h4);
    check("col_refetch_gnt", 64'(dmem_gnt), 64'h0);
    tick();
    check("refetch_valid", 64'(instr_read_data_valid), 64'h1);
    check("refetch_instr", 64'(instr_read_data), 64'hA500_0004);

    // Continuous data reads: fetch forced through on rounds 5 and 10
    prev_fetch = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) check($sformatf("starve_valid_%0d", k), 64'(instr_read_data_valid),
                       64'(prev_fetch));
      next_pc   = 32'h10;
      dmem_req  = 1'b1;
      dmem_addr = 32'h100;
      #1;
      exp_gnt = !(k == 5 || k == 10);
      check($sformatf("starve_gnt_%0d", k), 64'(dmem_gnt), 64'(exp_gnt));
      prev_fetch = !exp_gnt;
      tick();
    end
    check("starve_valid_13", 64'(instr_read_data_valid), 64'(prev_fetch));
    check("starve_rvalid_13", 64'(dmem_rvalid), 64'h1);

    // Out-of-range fetch over AHB while data writes proceed
    next_pc    = 32'h8000_0000;
    dmem_req   = 1'b1;
    dmem_we    = 1'b1;
    dmem_be    = 4'hF;
    dmem_addr  = 32'h200;
    dmem_wdata = 32'h1111_1111;
    #1;
    check("ahb0_gnt", 64'(dmem_gnt), 64'h1);
    check("ahb0_we", 64'(itcm_we), 64'h1);
    check("ahb0_req", 64'(ahb_if_req), 64'h0);
    tick();
    check("ahb1_req", 64'(ahb_if_req), 64'h1);
    check("ahb1_addr", 64'(ahb_if_addr), 64'h8000_0000);
    check("ahb1_addr_ahb", 64'(addr_AHB), 64'h1);
    check("ahb1_ivalid", 64'(instr_read_data_valid), 64'h0);
    #1;
    check("ahb1_gnt", 64'(dmem_gnt), 64'h1);
    tick();
    check("ahb2_req", 64'(ahb_if_req), 64'h1);
    check("ahb2_gnt", 64'(dmem_gnt), 64'h1);
    tick();
    ahb_if_ready = 1'b1;
    ahb_if_rdata = 32'hDEAD_BEEF;
    #1;
    check("ahb3_req", 64'(ahb_if_req), 64'h1);
    check("ahb3_gnt", 64'(dmem_gnt), 64'h1);
    check("ahb3_ivalid", 64'(instr_read_data_valid), 64'h0);
    tick();
    ahb_if_ready = 1'b0;
    ahb_if_rdata = '0;
    check("ahb_resp_valid", 64'(instr_read_data_valid), 64'h1);
    check("ahb_resp_instr", 64'(instr_read_data), 64'hDEAD_BEEF);
    check("ahb_resp_addr_ahb", 64'(addr_AHB), 64'h1);
    check("ahb_resp_req", 64'(ahb_if_req), 64'h0);
    check("ahb_resp_rvalid", 64'(dmem_rvalid), 64'h0);
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    next_pc  = 32'h24;
    tick();
    check("post_ahb_addr_ahb", 64'(addr_AHB), 64'h0);
    check("post_ahb_instr", 64'(instr_read_data), 64'hA500_0009);

    // Partial write then fetch of the same word
    dmem_req   = 1'b1;
    dmem_we    = 1'b1;
    dmem_be    = 4'b0011;
    dmem_addr  = 32'h20;
    dmem_wdata = 32'h1234_5678;
    next_pc    = 32'h40;
    #1;
    check("wr_we", 64'(itcm_we), 64'h1);
    check("wr_be", 64'(itcm_be), 64'h3);
    check("wr_addr", 64'(itcm_addr), 64'h8);
    check("wr_wdata", 64'(itcm_wdata), 64'h1234_5678);
    check("wr_gnt", 64'(dmem_gnt), 64'h1);
    tick();
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    dmem_be  = 4'h0;
    next_pc  = 32'h20;
    check("wr_ivalid", 64'(instr_read_data_valid), 64'h0);
    tick();
    check("rd_after_wr_valid", 64'(instr_read_data_valid), 64'h1);
    check("rd_after_wr_instr", 64'(instr_read_data), 64'hA500_5678);

    // Reset in the middle of an AHB wait
    next_pc = 32'h9000_0000;
    tick();
    check("rst_ahb_pre_req", 64'(ahb_if_req), 64'h1);
    #2;
    cpu_rstn = 1'b0;
    #1;
    check("rst_ahb_req", 64'(ahb_if_req), 64'h0);
    check("rst_ahb_addr_ahb", 64'(addr_AHB), 64'h0);
    check("rst_ahb_ivalid", 64'(instr_read_data_valid), 64'h0);
    check("rst_ahb_rvalid", 64'(dmem_rvalid), 64'h0);
    next_pc = 32'h30;
    tick();
    cpu_rstn = 1'b1;
    #1;
    check("post_rst_cs", 64'(itcm_cs), 64'h1);
    check("post_rst_addr", 64'(itcm_addr), 64'hC);
    tick();
    check("post_rst_valid", 64'(instr_read_data_valid), 64'h1);
    check("post_rst_instr", 64'(instr_read_data), 64'hA500_000C);
    check("post_rst_addr_ahb", 64'(addr_AHB), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
